// File: rtl/calc_result_bcd.sv
// ---------------------------------------------------------------------------
// calc_result_bcd
//
// Result formatter placed after the 6-bit signed divider and the other 6-bit
// ALU operations. A start pulse captures a signed quotient, a signed
// remainder and the error flag. Each value is turned into a sign bit and two
// BCD digits using shift-and-add-3 (double dabble), one bit per clock. The
// quotient is converted first, then the remainder. The finished result is
// then registered for the display driver and flagged with a one-cycle done
// pulse.
//
// Parameters:
//   SKIP_ON_ERR  1: a captured err skips conversion. Digits and signs read 0.
//                0: conversion runs normally and only err_out is raised.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   capture request
//   quotient   in   [5:0] two's-complement quotient
//   remainder  in   [5:0] two's-complement remainder
//   err        in   divider error (overflow / divide-by-zero)
//   busy       out  conversion in progress
//   done       out  one-cycle pulse, result outputs just updated
//   err_out    out  registered err of the last result
//   q_sign     out  quotient negative
//   q_tens     out  [3:0] quotient tens digit
//   q_ones     out  [3:0] quotient ones digit
//   r_sign     out  remainder negative
//   r_tens     out  [3:0] remainder tens digit
//   r_ones     out  [3:0] remainder ones digit
// ---------------------------------------------------------------------------
module calc_result_bcd #(
    parameter bit SKIP_ON_ERR = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] quotient,
    input  logic [5:0] remainder,
    input  logic       err,
    output logic       busy,
    output logic       done,
    output logic       err_out,
    output logic       q_sign,
    output logic [3:0] q_tens,
    output logic [3:0] q_ones,
    output logic       r_sign,
    output logic [3:0] r_tens,
    output logic [3:0] r_ones
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_Q = 2'd1,
        CONV_R = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t      state;
    logic [5:0]  mag;
    logic [5:0]  r_mag_hold;
    logic [7:0]  bcd;
    logic [7:0]  q_bcd_hold;
    logic [2:0]  bit_cnt;
    logic        q_sign_hold;
    logic        r_sign_hold;
    logic        err_hold;

    logic [7:0]  bcd_adj;
    logic [13:0] shifted;

    // Magnitude of a 6-bit two's-complement value. The result is unsigned,
    // so -32 gives 32.
    function automatic logic [5:0] abs6(input logic [5:0] x);
        abs6 = x[5] ? (~x + 6'd1) : x;
    endfunction

    // One double-dabble step: add 3 to any digit of 5 or more, then shift
    // the BCD/magnitude pair left by one. The top bit shifted out is always
    // zero because magnitudes never exceed 32.
    always_comb begin
        bcd_adj[3:0] = (bcd[3:0] >= 4'd5) ? (bcd[3:0] + 4'd3) : bcd[3:0];
        bcd_adj[7:4] = (bcd[7:4] >= 4'd5) ? (bcd[7:4] + 4'd3) : bcd[7:4];
        shifted      = {bcd_adj, mag} << 1;
    end

    // Control and datapath. The quotient digits are parked in a holding
    // register after their sixth shift, so the shared shifter can be reused
    // for the remainder. The visible outputs change only when leaving FIN.
    // A start seen while done is high is ignored, so a new capture is only
    // accepted in the IDLE cycle after the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mag         <= '0;
            r_mag_hold  <= '0;
            bcd         <= '0;
            q_bcd_hold  <= '0;
            bit_cnt     <= '0;
            q_sign_hold <= 1'b0;
            r_sign_hold <= 1'b0;
            err_hold    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_out     <= 1'b0;
            q_sign      <= 1'b0;
            q_tens      <= '0;
            q_ones      <= '0;
            r_sign      <= 1'b0;
            r_tens      <= '0;
            r_ones      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        err_hold <= err;
                        busy     <= 1'b1;
                        bcd      <= '0;
                        bit_cnt  <= '0;
                        if (err && SKIP_ON_ERR) begin
                            q_sign_hold <= 1'b0;
                            r_sign_hold <= 1'b0;
                            q_bcd_hold  <= '0;
                            mag         <= '0;
                            r_mag_hold  <= '0;
                            state       <= FIN;
                        end else begin
                            q_sign_hold <= quotient[5];
                            r_sign_hold <= remainder[5];
                            mag         <= abs6(quotient);
                            r_mag_hold  <= abs6(remainder);
                            state       <= CONV_Q;
                        end
                    end
                end

                CONV_Q: begin
                    if (bit_cnt == 3'd5) begin
                        q_bcd_hold <= shifted[13:6];
                        bcd        <= '0;
                        mag        <= r_mag_hold;
                        bit_cnt    <= '0;
                        state      <= CONV_R;
                    end else begin
                        {bcd, mag} <= shifted;
                        bit_cnt    <= bit_cnt + 3'd1;
                    end
                end

                CONV_R: begin
                    {bcd, mag} <= shifted;
                    if (bit_cnt == 3'd5) begin
                        bit_cnt <= '0;
                        state   <= FIN;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end

                FIN: begin
                    q_sign  <= q_sign_hold;
                    q_tens  <= q_bcd_hold[7:4];
                    q_ones  <= q_bcd_hold[3:0];
                    r_sign  <= r_sign_hold;
                    r_tens  <= bcd[7:4];
                    r_ones  <= bcd[3:0];
                    err_out <= err_hold;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_result_bcd.sv
// ---------------------------------------------------------------------------
// tb_calc_result_bcd
//
// Two formatter instances share one stimulus stream. One has SKIP_ON_ERR=1
// and the other has SKIP_ON_ERR=0. Each issued capture pushes the expected
// result and the expected done cycle into a queue per instance. A monitor
// per instance pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_calc_result_bcd;

    typedef struct packed {
        logic       qs;
        logic [3:0] qt;
        logic [3:0] qo;
        logic       rs;
        logic [3:0] rt;
        logic [3:0] ro;
        logic       eo;
    } res_t;

    typedef struct {
        res_t res;
        int   cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [5:0] quotient;
    logic [5:0] remainder;
    logic       err;

    logic       busy1, done1, err_out1, q_sign1, r_sign1;
    logic [3:0] q_tens1, q_ones1, r_tens1, r_ones1;
    logic       busy0, done0, err_out0, q_sign0, r_sign0;
    logic [3:0] q_tens0, q_ones0, r_tens0, r_ones0;

    exp_t exp1_q[$];
    exp_t exp0_q[$];

    int cyc;
    int checks;
    int failures;
    int n;

    calc_result_bcd #(.SKIP_ON_ERR(1'b1)) dut_skip (
        .clk(clk), .rst(rst), .start(start), .quotient(quotient),
        .remainder(remainder), .err(err), .busy(busy1), .done(done1),
        .err_out(err_out1), .q_sign(q_sign1), .q_tens(q_tens1),
        .q_ones(q_ones1), .r_sign(r_sign1), .r_tens(r_tens1), .r_ones(r_ones1)
    );

    calc_result_bcd #(.SKIP_ON_ERR(1'b0)) dut_conv (
        .clk(clk), .rst(rst), .start(start), .quotient(quotient),
        .remainder(remainder), .err(err), .busy(busy0), .done(done0),
        .err_out(err_out0), .q_sign(q_sign0), .q_tens(q_tens0),
        .q_ones(q_ones0), .r_sign(r_sign0), .r_tens(r_tens0), .r_ones(r_ones0)
    );

    // Clock and rising-edge counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    function automatic res_t mk(input logic qs, input logic [3:0] qt,
                                input logic [3:0] qo, input logic rs,
                                input logic [3:0] rt, input logic [3:0] ro,
                                input logic eo);
        mk = {qs, qt, qo, rs, rt, ro, eo};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h required=0x%0h at cycle %0d",
                     name, got, req, cyc);
        end
    endtask

    // Called at a falling edge. Holds start for one rising edge (edge N),
    // queues the expected results, and returns at the next falling edge.
    task automatic applyStimulus(input logic [5:0] q, input logic [5:0] r,
                                 input logic e, input res_t x1, input int l1,
                                 input res_t x0, input int l0,
                                 output int edge_n);
        exp_t ent;
        quotient  = q;
        remainder = r;
        err       = e;
        start     = 1'b1;
        edge_n    = cyc + 1;
        ent.res = x1; ent.cyc = edge_n + l1; exp1_q.push_back(ent);
        ent.res = x0; ent.cyc = edge_n + l0; exp0_q.push_back(ent);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Start pulse with no queued expectation, for captures that must be
    // ignored.
    task automatic pulseIgnored(input logic [5:0] q, input logic [5:0] r);
        quotient  = q;
        remainder = r;
        err       = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle();
        int k;
        k = 0;
        while ((exp1_q.size() != 0 || exp0_q.size() != 0) && k < 60) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 60) begin
            failures++;
            $display("[TB] FAIL done_timeout got pending=%0d/%0d required=0/0",
                     exp1_q.size(), exp0_q.size());
            exp1_q.delete();
            exp0_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_skip1"},
            {11'd0, busy1, done1, err_out1, q_sign1, q_tens1, q_ones1,
             r_sign1, r_tens1, r_ones1}, 32'd0);
        checkOutput({tag, "_skip0"},
            {11'd0, busy0, done0, err_out0, q_sign0, q_tens0, q_ones0,
             r_sign0, r_tens0, r_ones0}, 32'd0);
    endtask

    // Monitor for the SKIP_ON_ERR=1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done1 === 1'b1) begin
            if (exp1_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done_skip1 got done=1 required done=0 at cycle %0d", cyc);
            end else begin
                e = exp1_q.pop_front();
                checkOutput("result_skip1",
                    {13'd0, q_sign1, q_tens1, q_ones1, r_sign1, r_tens1,
                     r_ones1, err_out1}, {13'd0, e.res});
                checkOutput("latency_skip1", cyc, e.cyc);
                checkOutput("busy_at_done_skip1", {31'd0, busy1}, 32'd0);
            end
        end
    end

    // Monitor for the SKIP_ON_ERR=0 instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done0 === 1'b1) begin
            if (exp0_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done_skip0 got done=1 required done=0 at cycle %0d", cyc);
            end else begin
                e = exp0_q.pop_front();
                checkOutput("result_skip0",
                    {13'd0, q_sign0, q_tens0, q_ones0, r_sign0, r_tens0,
                     r_ones0, err_out0}, {13'd0, e.res});
                checkOutput("latency_skip0", cyc, e.cyc);
                checkOutput("busy_at_done_skip0", {31'd0, busy0}, 32'd0);
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got no finish required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        quotient  = '0;
        remainder = '0;
        err       = 1'b0;

        #12;
        checkAllZero("reset_state");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] basic positive 3 / 1");
        applyStimulus(6'd3, 6'd1, 1'b0, mk(0,4'd0,4'd3,0,4'd0,4'd1,0), 13,
                      mk(0,4'd0,4'd3,0,4'd0,4'd1,0), 13, n);
        checkOutput("busy_after_capture", {30'd0, busy1, busy0}, 32'd3);
        waitIdle();

        $display("[TB] negative -3 / -1");
        applyStimulus(6'b111101, 6'b111111, 1'b0,
                      mk(1,4'd0,4'd3,1,4'd0,4'd1,0), 13,
                      mk(1,4'd0,4'd3,1,4'd0,4'd1,0), 13, n);
        waitIdle();

        $display("[TB] boundary -32 / 31");
        applyStimulus(6'b100000, 6'd31, 1'b0,
                      mk(1,4'd3,4'd2,0,4'd3,4'd1,0), 13,
                      mk(1,4'd3,4'd2,0,4'd3,4'd1,0), 13, n);
        waitIdle();

        $display("[TB] error case 25 / -10");
        applyStimulus(6'd25, 6'b110110, 1'b1,
                      mk(0,4'd0,4'd0,0,4'd0,4'd0,1), 1,
                      mk(0,4'd2,4'd5,1,4'd1,4'd0,1), 13, n);
        waitIdle();

        $display("[TB] start while busy ignored");
        applyStimulus(6'd7, 6'd2, 1'b0, mk(0,4'd0,4'd7,0,4'd0,4'd2,0), 13,
                      mk(0,4'd0,4'd7,0,4'd0,4'd2,0), 13, n);
        while (cyc < n + 4) @(negedge clk);
        pulseIgnored(6'b101100, 6'd5);
        waitIdle();

        $display("[TB] start during done ignored, next cycle accepted");
        applyStimulus(6'd13, 6'b110111, 1'b0,
                      mk(0,4'd1,4'd3,1,4'd0,4'd9,0), 13,
                      mk(0,4'd1,4'd3,1,4'd0,4'd9,0), 13, n);
        while (cyc < n + 13) @(negedge clk);
        quotient  = 6'd1;
        remainder = 6'd1;
        err       = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        applyStimulus(6'b101111, 6'd0, 1'b0,
                      mk(1,4'd1,4'd7,0,4'd0,4'd0,0), 13,
                      mk(1,4'd1,4'd7,0,4'd0,4'd0,0), 13, n);
        waitIdle();

        $display("[TB] reset mid-conversion");
        applyStimulus(6'd22, 6'd3, 1'b0, mk(0,4'd2,4'd2,0,4'd0,4'd3,0), 13,
                      mk(0,4'd2,4'd2,0,4'd0,4'd3,0), 13, n);
        while (cyc < n + 6) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp1_q.delete();
        exp0_q.delete();
        #1;
        checkAllZero("mid_reset_outputs");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] conversion after reset -8 / -31");
        applyStimulus(6'b111000, 6'b100001, 1'b0,
                      mk(1,4'd0,4'd8,1,4'd3,4'd1,0), 13,
                      mk(1,4'd0,4'd8,1,4'd3,4'd1,0), 13, n);
        waitIdle();

        $display("[TB] zero / zero");
        applyStimulus(6'd0, 6'd0, 1'b0, mk(0,4'd0,4'd0,0,4'd0,4'd0,0), 13,
                      mk(0,4'd0,4'd0,0,4'd0,4'd0,0), 13, n);
        waitIdle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
